// File: rtl/touch_scan_ctrl.sv
// touch_scan_ctrl: periodic touch-panel scan sequencer with press/release debounce, 4-entry event FIFO and Avalon-MM slave.
// Latency: avl_readdata and irq are registered (1 cycle); an event is in the FIFO 1 cycle after EVAL.
// Backpressure: none toward the driver; a full FIFO drops new events and sets sticky ovf.
// Optional: `define TOUCH_MOVE_FILTER_EN suppresses moves smaller than MOVE_THR on both axes.
module touch_scan_ctrl #(
  parameter int CLK_FREQ    = 50000000,
  parameter int SCAN_HZ     = 100,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int DEB_CNT     = 2,
  parameter int MOVE_THR    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        scan_req,
  input  logic        scan_done,
  input  logic        scan_err,
  input  logic [2:0]  tp_num,
  input  logic [31:0] tp1_xy,
  input  logic [2:0]  avl_address,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic        avl_read,
  output logic [31:0] avl_readdata,
  output logic        irq
);

  localparam logic [31:0] PER_LAST = 32'(CLK_FREQ / SCAN_HZ - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  DEB_N    = 3'(DEB_CNT);

  // Reject configurations the 3-bit debounce counter or the move filter cannot honour.
  if (DEB_CNT < 1 || DEB_CNT > 7 || MOVE_THR < 1 || CLK_FREQ < SCAN_HZ) begin : g_bad_cfg
    $error("touch_scan_ctrl: DEB_CNT must be 1..7, MOVE_THR >= 1, CLK_FREQ >= SCAN_HZ");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUSY, S_EVAL} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_per_cnt, r_tmo_cnt;
  logic        r_en, r_irq_en, r_ovf, r_tmo, r_err;
  logic        r_pressed, w_pressed_nxt;
  logic [2:0]  r_deb_cnt, w_deb_nxt, w_deb_inc;
  logic        r_smp_touch;
  logic [29:0] r_smp_xy, r_last_xy, w_last_nxt;
  logic [31:0] r_fifo [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_fifo_cnt;
  logic        r_scan_req, r_irq;
  logic [31:0] r_readdata, w_rd_mux;

  logic        w_req_start, w_set_tmo, w_set_err, w_smp_ld, w_eval;
  logic        w_push, w_push_ok, w_drop, w_pop, w_full, w_move_ok;
  logic [31:0] w_push_dat;
  logic        w_ctrl_wr, w_clr;
  logic        w_unused;

  // Field bits beyond the 15-bit coordinates and unused ctrl bits are intentionally ignored.
  assign w_unused = ^{tp1_xy[31], tp1_xy[15], avl_writedata[31:3]};

  assign scan_req     = r_scan_req;
  assign irq          = r_irq;
  assign avl_readdata = r_readdata;

  assign w_ctrl_wr = avl_write && (avl_address == 3'd2);
  assign w_clr     = w_ctrl_wr && avl_writedata[2];
  assign w_full    = (r_fifo_cnt == 3'd4);
  assign w_pop     = avl_read && (avl_address == 3'd1) && (r_fifo_cnt != 3'd0);
  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_deb_inc = r_deb_cnt + 3'd1;

  // Next-state logic of the scan sequencer; en is only sampled outside a transaction.
  always_comb begin
    w_state_nxt = r_state;
    w_req_start = 1'b0;
    w_set_tmo   = 1'b0;
    w_set_err   = 1'b0;
    w_smp_ld    = 1'b0;
    w_eval      = 1'b0;
    case (r_state)
      S_IDLE: if (r_en) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_per_cnt == PER_LAST) begin
          w_state_nxt = S_BUSY;
          w_req_start = 1'b1;
        end
      end
      S_BUSY: begin
        if (scan_err) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (scan_done) begin
          w_smp_ld    = 1'b1;
          w_state_nxt = S_EVAL;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_EVAL: begin
        w_eval      = 1'b1;
        w_state_nxt = r_en ? S_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef TOUCH_MOVE_FILTER_EN
  localparam logic [14:0] THR = 15'(MOVE_THR);
  logic [14:0] w_dx, w_dy;
  assign w_dx = (r_smp_xy[29:15] >= r_last_xy[29:15]) ? (r_smp_xy[29:15] - r_last_xy[29:15])
                                                       : (r_last_xy[29:15] - r_smp_xy[29:15]);
  assign w_dy = (r_smp_xy[14:0] >= r_last_xy[14:0]) ? (r_smp_xy[14:0] - r_last_xy[14:0])
                                                     : (r_last_xy[14:0] - r_smp_xy[14:0]);
  assign w_move_ok = (w_dx >= THR) || (w_dy >= THR);
`else
  assign w_move_ok = (r_smp_xy != r_last_xy);
`endif

  // Debounce and event generation, evaluated once per completed scan.
  always_comb begin
    w_push        = 1'b0;
    w_push_dat    = 32'd0;
    w_pressed_nxt = r_pressed;
    w_deb_nxt     = r_deb_cnt;
    w_last_nxt    = r_last_xy;
    if (w_eval) begin
      if (r_smp_touch != r_pressed) begin
        if (w_deb_inc == DEB_N) begin
          w_pressed_nxt = ~r_pressed;
          w_deb_nxt     = 3'd0;
          w_push        = 1'b1;
          if (!r_pressed) begin
            w_push_dat = {2'b01, r_smp_xy};
            w_last_nxt = r_smp_xy;
          end else begin
            w_push_dat = {2'b11, r_last_xy};
          end
        end else begin
          w_deb_nxt = w_deb_inc;
        end
      end else begin
        w_deb_nxt = 3'd0;
        if (r_pressed && r_smp_touch && w_move_ok) begin
          w_push     = 1'b1;
          w_push_dat = {2'b10, r_smp_xy};
          w_last_nxt = r_smp_xy;
        end
      end
    end
  end

  // Register read mux; the FIFO data port reads 0 when empty.
  always_comb begin
    w_rd_mux = 32'd0;
    case (avl_address)
      3'd0: w_rd_mux = {24'd0, r_fifo_cnt, r_err, r_tmo, r_ovf, (r_state == S_BUSY), r_pressed};
      3'd1: w_rd_mux = (r_fifo_cnt != 3'd0) ? r_fifo[r_rd_ptr] : 32'd0;
      3'd2: w_rd_mux = {30'd0, r_irq_en, r_en};
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Sequencer state, counters, sample latch and debounce state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= 32'd0;
      r_tmo_cnt   <= 32'd0;
      r_scan_req  <= 1'b0;
      r_smp_touch <= 1'b0;
      r_smp_xy    <= 30'd0;
      r_pressed   <= 1'b0;
      r_deb_cnt   <= 3'd0;
      r_last_xy   <= 30'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_per_cnt  <= (r_state == S_WAIT) ? r_per_cnt + 32'd1 : 32'd0;
      r_tmo_cnt  <= (r_state == S_BUSY) ? r_tmo_cnt + 32'd1 : 32'd0;
      r_scan_req <= w_req_start;
      if (w_smp_ld) begin
        r_smp_touch <= (tp_num != 3'd0);
        r_smp_xy    <= {tp1_xy[30:16], tp1_xy[14:0]};
      end
      r_pressed <= w_pressed_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_last_xy <= w_last_nxt;
    end
  end

  // Control register, sticky flags, FIFO pointers, irq and read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_ovf      <= 1'b0;
      r_tmo      <= 1'b0;
      r_err      <= 1'b0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_fifo_cnt <= 3'd0;
      r_irq      <= 1'b0;
      r_readdata <= 32'd0;
    end else begin
      if (w_ctrl_wr) begin
        r_en     <= avl_writedata[0];
        r_irq_en <= avl_writedata[1];
      end
      r_ovf <= (r_ovf & ~w_clr) | w_drop;
      r_tmo <= (r_tmo & ~w_clr) | w_set_tmo;
      r_err <= (r_err & ~w_clr) | w_set_err;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
      r_fifo_cnt <= r_fifo_cnt + {2'd0, w_push_ok} - {2'd0, w_pop};
      r_irq      <= r_irq_en && (r_fifo_cnt != 3'd0);
      if (avl_read) r_readdata <= w_rd_mux;
    end
  end

  // Event storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= w_push_dat;
  end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Bench for touch_scan_ctrl: directed scenarios plus randomized scans checked against a queue-based model.
`timescale 1ns/1ps
module tb_touch_scan_ctrl;
  localparam int PERIOD = 10;
  localparam int TMO    = 50;
  localparam int DEB    = 2;
  localparam int THR    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_req;
  logic        scan_done = 1'b0;
  logic        scan_err = 1'b0;
  logic [2:0]  tp_num = 3'd0;
  logic [31:0] tp1_xy = 32'd0;
  logic [2:0]  avl_address = 3'd0;
  logic        avl_write = 1'b0;
  logic [31:0] avl_writedata = 32'd0;
  logic        avl_read = 1'b0;
  logic [31:0] avl_readdata;
  logic        irq;

  touch_scan_ctrl #(.CLK_FREQ(1000), .SCAN_HZ(100), .TIMEOUT_CYC(TMO), .DEB_CNT(DEB), .MOVE_THR(THR)) dut (
    .clk(clk), .rst_n(rst_n), .scan_req(scan_req), .scan_done(scan_done), .scan_err(scan_err),
    .tp_num(tp_num), .tp1_xy(tp1_xy), .avl_address(avl_address), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_read(avl_read), .avl_readdata(avl_readdata), .irq(irq));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: flags, press state and the event queue as the CPU should see them.
  logic [31:0] m_q[$];
  bit m_pressed, m_ovf, m_tmo, m_err, m_en, m_irq_en;
  int m_deb, m_lx, m_ly;
  logic [31:0] last_exp;

  function automatic logic [31:0] status_exp(input bit busy);
    return {24'd0, 3'(m_q.size()), m_err, m_tmo, m_ovf, busy, m_pressed};
  endfunction

  function automatic logic [31:0] ev(input logic [1:0] t, input int x, input int y);
    return {t, 15'(x), 15'(y)};
  endfunction

  task automatic model_push(input logic [31:0] e);
    if (m_q.size() < 4) m_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic model_eval(input bit touch, input int x, input int y);
    bit moved;
    if (touch != m_pressed) begin
      m_deb++;
      if (m_deb == DEB) begin
        m_deb = 0;
        m_pressed = touch;
        if (touch) begin
          m_lx = x; m_ly = y;
          model_push(ev(2'b01, x, y));
        end else begin
          model_push(ev(2'b11, m_lx, m_ly));
        end
      end
    end else begin
      m_deb = 0;
      if (touch) begin
`ifdef TOUCH_MOVE_FILTER_EN
        moved = ((x > m_lx ? x - m_lx : m_lx - x) >= THR) || ((y > m_ly ? y - m_ly : m_ly - y) >= THR);
`else
        moved = (x != m_lx) || (y != m_ly);
`endif
        if (moved) begin
          model_push(ev(2'b10, x, y));
          m_lx = x; m_ly = y;
        end
      end
    end
  endtask

  // scan_req monitor: records the cycle of each pulse and checks it lasts one cycle.
  bit req_seen = 1'b0;
  bit prev_req = 1'b0;
  int req_cyc = 0;
  always @(negedge clk) begin
    if (scan_req) begin
      chk("req_width", 32'(prev_req), 32'd0);
      req_seen = 1'b1;
      req_cyc = cyc;
    end
    prev_req = scan_req;
  end

  bit exp_req_vld = 1'b0;
  int exp_req = 0;
  int wr_cyc = 0;

  task automatic avl_rd(input logic [2:0] a, output logic [31:0] d);
    avl_address = a; avl_read = 1'b1;
    @(negedge clk);
    avl_read = 1'b0;
    d = avl_readdata;
  endtask

  task automatic avl_wr(input logic [2:0] a, input logic [31:0] d);
    avl_address = a; avl_writedata = d; avl_write = 1'b1; wr_cyc = cyc;
    @(negedge clk);
    avl_write = 1'b0;
  endtask

  task automatic rd_cmp(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    avl_rd(a, d);
    chk(tag, d, exp);
    last_exp = exp;
  endtask

  task automatic pop_cmp();
    logic [31:0] e;
    e = (m_q.size() != 0) ? m_q.pop_front() : 32'd0;
    rd_cmp("pop", 3'd1, e);
  endtask

  task automatic ctrl_wr(input bit en, input bit ie, input bit clr);
    avl_wr(3'd2, {29'd0, clr, ie, en});
    m_en = en; m_irq_en = ie;
    if (clr) begin m_ovf = 0; m_tmo = 0; m_err = 0; end
  endtask

  task automatic wait_req(output bit ok);
    int g = 0;
    while (!req_seen && g < 200) begin @(negedge clk); g++; end
    ok = req_seen;
    chk("req_seen", 32'(ok), 32'd1);
    if (ok && exp_req_vld) chk("req_cycle", req_cyc, exp_req);
    req_seen = 1'b0;
  endtask

  // kind 0: done, 1: err, 2: no response (timeout).
  task automatic do_scan(input int kind, input bit touch, input int x, input int y, input int dly, input bit rd_busy);
    bit ok;
    int n;
    wait_req(ok);
    if (!ok) return;
    if (rd_busy) rd_cmp("status_busy", 3'd0, status_exp(1'b1));
    repeat (dly) @(negedge clk);
    if (kind == 2) begin
      while (cyc < req_cyc + TMO + 1) @(negedge clk);
      m_tmo = 1'b1;
      exp_req = req_cyc + TMO + PERIOD;
    end else begin
      tp_num = touch ? 3'($urandom_range(1, 7)) : 3'd0;
      tp1_xy = {1'b0, 15'(x), 1'b0, 15'(y)};
      if (kind == 0) scan_done = 1'b1; else scan_err = 1'b1;
      n = cyc;
      @(negedge clk);
      scan_done = 1'b0; scan_err = 1'b0;
      if (kind == 0) begin
        // done cycle, one EVAL cycle, then a full period in WAIT
        exp_req = n + 2 + PERIOD;
        model_eval(touch, x, y);
      end else begin
        exp_req = n + 1 + PERIOD;
        m_err = 1'b1;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic post_checks();
    rd_cmp("status", 3'd0, status_exp(1'b0));
    @(negedge clk);
    chk("irq", 32'(irq), 32'(m_irq_en && m_q.size() != 0));
  endtask

  task automatic drain();
    for (int k = 0; k < 5; k++) pop_cmp();
    @(negedge clk);
    chk("irq_drained", 32'(irq), 32'd0);
  endtask

  initial begin
    bit ok, cur_touch;
    int kind, x, y, op, nops;
    logic [31:0] d;
    logic [2:0] ba;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_scan_req", 32'(scan_req), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", avl_readdata, 32'd0);
    rd_cmp("rst_status", 3'd0, 32'd0);
    rd_cmp("rst_ctrl", 3'd2, 32'd0);

    // Enable: IDLE sees en one cycle after the write, then a full WAIT period.
    ctrl_wr(1'b1, 1'b1, 1'b0);
    exp_req = wr_cyc + 2 + PERIOD;
    exp_req_vld = 1'b1;

    // Press after two touched scans, then moves.
    do_scan(0, 1, 100, 50, 2, 1); post_checks();
    do_scan(0, 1, 100, 50, 3, 0); post_checks();
    rd_cmp("press_word", 3'd1, {2'b01, 15'd100, 15'd50});
    void'(m_q.pop_front());
    do_scan(0, 1, 102, 50, 1, 0); post_checks();
    do_scan(0, 1, 104, 50, 1, 0); post_checks();
`ifdef TOUCH_MOVE_FILTER_EN
    rd_cmp("move_word", 3'd1, {2'b10, 15'd104, 15'd50});
`else
    rd_cmp("move_word", 3'd1, {2'b10, 15'd102, 15'd50});
`endif
    void'(m_q.pop_front());
    drain();

    // Overflow: five large moves with no CPU reads.
    for (int i = 0; i < 5; i++) begin
      do_scan(0, 1, 200 + 10 * i, 60, 2, 0);
      post_checks();
    end
    // Simultaneous write and read of ctrl returns the old value.
    avl_address = 3'd2; avl_writedata = 32'h6; avl_write = 1'b1; avl_read = 1'b1;
    @(negedge clk);
    avl_write = 1'b0; avl_read = 1'b0;
    chk("ctrl_rw_old", avl_readdata, 32'h3);
    m_en = 0; m_irq_en = 1; m_ovf = 0; m_tmo = 0; m_err = 0;
    rd_cmp("status_clr", 3'd0, status_exp(1'b0));
    rd_cmp("ctrl_after_clr", 3'd2, 32'h2);
    chk("irq_held", 32'(irq), 32'd1);
    drain();
    ctrl_wr(1'b1, 1'b1, 1'b0);
    exp_req = wr_cyc + 2 + PERIOD;

    // Timeout, then an error with touched data that must be discarded.
    do_scan(2, 0, 0, 0, 1, 1); post_checks();
    do_scan(1, 1, 900, 900, 2, 0); post_checks();
    ctrl_wr(1'b1, 1'b1, 1'b1);

    // Randomized scans and CPU traffic.
    cur_touch = m_pressed;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 99);
      kind = (op < 85) ? 0 : (op < 93) ? 1 : 2;
      if ($urandom_range(0, 3) == 0) cur_touch = !cur_touch;
      x = ($urandom_range(0, 2) == 0) ? m_lx : 1000 + $urandom_range(0, 12);
      y = ($urandom_range(0, 2) == 0) ? m_ly : 500 + $urandom_range(0, 8);
      do_scan(kind, cur_touch, x, y, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      post_checks();
      nops = $urandom_range(0, 3);
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 3))
          0: pop_cmp();
          1: rd_cmp("ctrl", 3'd2, {30'd0, m_irq_en, m_en});
          2: ctrl_wr(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          default: begin
            ba = 3'($urandom_range(3, 7));
            avl_wr(ba, $urandom);
            rd_cmp("bad_addr", ba, 32'd0);
            rd_cmp("ctrl_kept", 3'd2, {30'd0, m_irq_en, m_en});
          end
        endcase
      end
      @(negedge clk);
      chk("irq_rand", 32'(irq), 32'(m_irq_en && m_q.size() != 0));
      chk("rd_hold", avl_readdata, last_exp);
    end

    // Reset in the middle of a transaction with three queued events.
    drain();
    for (int k = 0; k < 12 && m_q.size() < 3; k++) begin
      do_scan(0, 1, 300 + 10 * k, 70, 1, 0);
      post_checks();
    end
    chk("queued3", 32'(m_q.size() >= 3), 32'd1);
    wait_req(ok);
    rd_cmp("status_pre_rst", 3'd0, status_exp(1'b1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_scan_req", 32'(scan_req), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_readdata", avl_readdata, 32'd0);
    rd_cmp("mid_rst_status", 3'd0, 32'd0);
    rd_cmp("mid_rst_ctrl", 3'd2, 32'd0);
    req_seen = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_req_after_rst", 32'(req_seen), 32'd0);
    chk("irq_after_rst", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

endmodule
